// File: rtl/cdb_age_arbiter_pkg.sv
// Shared CDB arbitration definitions.
// FU index order matches the FU_REQUESTS flatten order.
package sys_defs;

  localparam int NUM_FU_TOTAL = 6;
  localparam int N = 3;

  localparam int CDB_ARB_AGE_W = 4;
  localparam int CDB_STARVE_THRESH = 8;
  localparam int CDB_PERF_W = 16;

  typedef logic [CDB_ARB_AGE_W-1:0] CDB_AGE_T;

  // Branch 0, ALU 1..2, MEM 3, MULT 4..5
  localparam int FU_IDX_BRANCH = 0;
  localparam int FU_IDX_ALU = 1;
  localparam int FU_IDX_MEM = 3;
  localparam int FU_IDX_MULT = 4;

endpackage

// File: rtl/cdb_age_arbiter_slot_alloc.sv
// Two-pass CDB slot filler: urgent requesters first,
// then normal requesters, both in ascending index order.
module cdb_slot_alloc #(
  parameter int NUM_REQ = 6,
  parameter int N = 3
) (
  input  logic [NUM_REQ-1:0]        urgent,
  input  logic [NUM_REQ-1:0]        normal,
  output logic [N-1:0][NUM_REQ-1:0] gnt_bus_next,
  output logic [NUM_REQ-1:0]        gnt_next
);

  localparam int SW = $clog2(N + 1);

  logic [SW-1:0] used;

  always_comb begin
    gnt_bus_next = '0;
    used = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (urgent[i]) begin
        for (int s = 0; s < N; s++)
          if (used == SW'(s))
            gnt_bus_next[s][i] = 1'b1;
        if (used != SW'(N))
          used = used + SW'(1);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (normal[i]) begin
        for (int s = 0; s < N; s++)
          if (used == SW'(s))
            gnt_bus_next[s][i] = 1'b1;
        if (used != SW'(N))
          used = used + SW'(1);
      end
    end
    gnt_next = '0;
    for (int s = 0; s < N; s++)
      gnt_next = gnt_next | gnt_bus_next[s];
  end

endmodule

// File: rtl/cdb_age_arbiter.sv
// Starvation-free CDB arbiter: ages losing requesters and
// promotes them to urgent; grants are registered.
import sys_defs::*;

module cdb_age_arbiter #(
  parameter int NUM_REQ = NUM_FU_TOTAL,
  parameter int N = sys_defs::N,
  parameter int AGE_W = CDB_ARB_AGE_W,
  parameter int STARVE_THRESH = CDB_STARVE_THRESH,
  parameter int PERF_W = CDB_PERF_W
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req,
  input  logic                            flush,
  output logic [NUM_REQ-1:0]              gnt,
  output logic [N-1:0][NUM_REQ-1:0]       gnt_bus,
  output logic [NUM_REQ-1:0]              urgent_mask,
  output logic [PERF_W-1:0]               promote_cnt,
  output logic [NUM_REQ-1:0][AGE_W-1:0]   age_dbg
);

  localparam logic [AGE_W-1:0] AGE_MAX = '1;
  localparam logic [AGE_W-1:0] THR = AGE_W'(STARVE_THRESH);
  localparam logic [AGE_W-1:0] THR_M1 = AGE_W'(STARVE_THRESH - 1);
  localparam int CW = $clog2(NUM_REQ + 1);

  logic [NUM_REQ-1:0][AGE_W-1:0] age_q;
  logic [NUM_REQ-1:0]            normal_mask;
  logic [NUM_REQ-1:0]            gnt_next;
  logic [NUM_REQ-1:0]            lose;
  logic [N-1:0][NUM_REQ-1:0]     gnt_bus_next;
  logic [CW-1:0]                 n_cross;
  logic [PERF_W:0]               cnt_sum;

  always_comb begin
    urgent_mask = '0;
    for (int i = 0; i < NUM_REQ; i++)
      urgent_mask[i] = req[i] && (age_q[i] >= THR);
  end

  assign normal_mask = req & ~urgent_mask;

  cdb_slot_alloc #(
    .NUM_REQ (NUM_REQ),
    .N       (N)
  ) u_alloc (
    .urgent       (urgent_mask),
    .normal       (normal_mask),
    .gnt_bus_next (gnt_bus_next),
    .gnt_next     (gnt_next)
  );

  assign lose = req & ~gnt_next;

  // Threshold-1 losers are the ones that become urgent this edge
  always_comb begin
    n_cross = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (lose[i] && (age_q[i] == THR_M1))
        n_cross = n_cross + CW'(1);
    cnt_sum = {1'b0, promote_cnt} + (PERF_W + 1)'(n_cross);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      gnt <= '0;
      gnt_bus <= '0;
      age_q <= '0;
      promote_cnt <= '0;
    end else if (flush) begin
      gnt <= '0;
      gnt_bus <= '0;
      age_q <= '0;
    end else begin
      gnt <= gnt_next;
      gnt_bus <= gnt_bus_next;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!lose[i])
          age_q[i] <= '0;
        else if (age_q[i] != AGE_MAX)
          age_q[i] <= age_q[i] + AGE_W'(1);
      end
      promote_cnt <= cnt_sum[PERF_W] ? '1 : cnt_sum[PERF_W-1:0];
    end
  end

  assign age_dbg = age_q;

endmodule

// File: tb/tb_cdb_age_arbiter.sv
// Randomized and directed bench for cdb_age_arbiter
// against a list-based reference model.
module tb_cdb_age_arbiter;

  logic             clock = 1'b0;
  logic             reset;
  logic             flush;
  logic [5:0]       req;
  logic [5:0]       gnt;
  logic [2:0][5:0]  gnt_bus;
  logic [5:0]       urgent_mask;
  logic [15:0]      promote_cnt;
  logic [5:0][3:0]  age_dbg;

  int checks = 0;
  int failures = 0;

  int              age_m [6];
  int              prom_m;
  logic [5:0]      gnt_m;
  logic [5:0]      urg_m;
  logic [5:0]      obs_urg;
  logic [2:0][5:0] bus_m;

  cdb_age_arbiter dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .flush       (flush),
    .gnt         (gnt),
    .gnt_bus     (gnt_bus),
    .urgent_mask (urgent_mask),
    .promote_cnt (promote_cnt),
    .age_dbg     (age_dbg)
  );

  always #5 clock = ~clock;

  function automatic logic [5:0][3:0] pack_age();
    logic [5:0][3:0] r;
    for (int i = 0; i < 6; i++) r[i] = 4'(age_m[i]);
    return r;
  endfunction

  task automatic model_clear(input logic clr_prom);
    for (int i = 0; i < 6; i++) age_m[i] = 0;
    gnt_m = '0;
    bus_m = '0;
    if (clr_prom) prom_m = 0;
  endtask

  // Drive one cycle, advance the model, sample after the edge
  task automatic tick(input logic [5:0] r, input logic f);
    int order [$];
    logic [5:0] won;
    logic [2:0][5:0] nb;
    req = r;
    flush = f;
    #1;
    obs_urg = urgent_mask;
    urg_m = '0;
    for (int i = 0; i < 6; i++)
      if (r[i] && age_m[i] >= 8) urg_m[i] = 1'b1;
    order = {};
    for (int i = 0; i < 6; i++) if (urg_m[i]) order.push_back(i);
    for (int i = 0; i < 6; i++) if (r[i] && !urg_m[i]) order.push_back(i);
    won = '0;
    nb = '0;
    for (int k = 0; k < order.size() && k < 3; k++) begin
      nb[k][order[k]] = 1'b1;
      won[order[k]] = 1'b1;
    end
    @(posedge clock);
    #1;
    if (f) begin
      model_clear(1'b0);
    end else begin
      gnt_m = won;
      bus_m = nb;
      for (int i = 0; i < 6; i++) begin
        if (r[i] && !won[i]) begin
          if (age_m[i] == 7) prom_m = (prom_m == 65535) ? 65535 : prom_m + 1;
          age_m[i] = (age_m[i] == 15) ? 15 : age_m[i] + 1;
        end else begin
          age_m[i] = 0;
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req = '1;
    flush = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    model_clear(1'b1);
    checks++; if (gnt !== 6'b0) begin failures++; $display("FAIL reset_gnt got=%b exp=0", gnt); end
    checks++; if (promote_cnt !== 16'd0) begin failures++; $display("FAIL reset_prom got=%0d exp=0", promote_cnt); end
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick(6'b0, 1'b0);
      checks++; if (gnt !== 6'b0) begin failures++; $display("FAIL idle_gnt c=%0d got=%b exp=0", c, gnt); end
      checks++; if (gnt_bus !== 18'b0) begin failures++; $display("FAIL idle_bus c=%0d got=%b exp=0", c, gnt_bus); end
      checks++; if (age_dbg !== 24'b0) begin failures++; $display("FAIL idle_age c=%0d got=%h exp=0", c, age_dbg); end
      checks++; if (promote_cnt !== 16'd0) begin failures++; $display("FAIL idle_prom c=%0d got=%0d exp=0", c, promote_cnt); end
      checks++; if (obs_urg !== 6'b0) begin failures++; $display("FAIL idle_urg c=%0d got=%b exp=0", c, obs_urg); end
    end
  endtask

  task automatic test_single();
    tick(6'b100000, 1'b0);
    checks++; if (gnt !== 6'b100000) begin failures++; $display("FAIL single_gnt got=%b exp=100000", gnt); end
    checks++; if (gnt_bus[0] !== 6'b100000) begin failures++; $display("FAIL single_bus0 got=%b exp=100000", gnt_bus[0]); end
    checks++; if (gnt_bus[2:1] !== 12'b0) begin failures++; $display("FAIL single_bus12 got=%b exp=0", gnt_bus[2:1]); end
    tick(6'b000000, 1'b0);
    checks++; if (gnt !== 6'b0) begin failures++; $display("FAIL single_after got=%b exp=0", gnt); end
  endtask

  task automatic test_starve();
    for (int c = 1; c <= 8; c++) begin
      tick(6'b111111, 1'b0);
      checks++; if (gnt !== 6'b000111) begin failures++; $display("FAIL starve_gnt c=%0d got=%b exp=000111", c, gnt); end
      checks++; if (gnt_bus !== {6'b000100, 6'b000010, 6'b000001}) begin failures++; $display("FAIL starve_bus c=%0d got=%b", c, gnt_bus); end
      checks++; if (age_dbg[5] !== 4'(c)) begin failures++; $display("FAIL starve_age5 c=%0d got=%0d exp=%0d", c, age_dbg[5], c); end
    end
    checks++; if (promote_cnt !== 16'd3) begin failures++; $display("FAIL starve_prom got=%0d exp=3", promote_cnt); end
    tick(6'b111111, 1'b0);
    checks++; if (obs_urg !== 6'b111000) begin failures++; $display("FAIL starve_urg got=%b exp=111000", obs_urg); end
    checks++; if (gnt !== 6'b111000) begin failures++; $display("FAIL starve_promo got=%b exp=111000", gnt); end
    checks++; if (gnt_bus[0] !== 6'b001000) begin failures++; $display("FAIL starve_bus0 got=%b exp=001000", gnt_bus[0]); end
    checks++; if (age_dbg[5:3] !== 12'b0) begin failures++; $display("FAIL starve_clr got=%h exp=0", age_dbg[5:3]); end
  endtask

  task automatic test_flush();
    tick(6'b0, 1'b0);
    repeat (5) tick(6'b111111, 1'b0);
    tick(6'b111111, 1'b1);
    checks++; if (gnt !== 6'b0) begin failures++; $display("FAIL flush_gnt got=%b exp=0", gnt); end
    checks++; if (age_dbg !== 24'b0) begin failures++; $display("FAIL flush_age got=%h exp=0", age_dbg); end
    checks++; if (promote_cnt !== 16'd3) begin failures++; $display("FAIL flush_prom got=%0d exp=3", promote_cnt); end
    for (int c = 1; c <= 8; c++) begin
      tick(6'b111111, 1'b0);
      checks++; if (gnt !== 6'b000111) begin failures++; $display("FAIL flush_win c=%0d got=%b exp=000111", c, gnt); end
    end
    tick(6'b111111, 1'b0);
    checks++; if (gnt !== 6'b111000) begin failures++; $display("FAIL flush_promo got=%b exp=111000", gnt); end
  endtask

  task automatic test_drop();
    tick(6'b0, 1'b0);
    repeat (6) tick(6'b111111, 1'b0);
    checks++; if (age_dbg[5] !== 4'd6) begin failures++; $display("FAIL drop_age6 got=%0d exp=6", age_dbg[5]); end
    tick(6'b011111, 1'b0);
    checks++; if (age_dbg[5] !== 4'd0) begin failures++; $display("FAIL drop_age0 got=%0d exp=0", age_dbg[5]); end
    for (int j = 0; j <= 8; j++) begin
      tick(6'b111111, 1'b0);
      checks++; if (obs_urg[5] !== (j == 8)) begin failures++; $display("FAIL drop_urg5 j=%0d got=%b exp=%b", j, obs_urg[5], j == 8); end
      checks++; if (gnt !== gnt_m) begin failures++; $display("FAIL drop_gnt j=%0d got=%b exp=%b", j, gnt, gnt_m); end
      checks++; if (age_dbg !== pack_age()) begin failures++; $display("FAIL drop_age j=%0d got=%h exp=%h", j, age_dbg, pack_age()); end
    end
  endtask

  task automatic test_random();
    logic [5:0] r;
    logic f;
    for (int c = 0; c < 400; c++) begin
      r = 6'($urandom) | 6'($urandom);
      f = ($urandom_range(0, 15) == 0);
      tick(r, f);
      checks++; if (obs_urg !== urg_m) begin failures++; $display("FAIL rnd_urg c=%0d got=%b exp=%b", c, obs_urg, urg_m); end
      checks++; if (gnt !== gnt_m) begin failures++; $display("FAIL rnd_gnt c=%0d got=%b exp=%b", c, gnt, gnt_m); end
      checks++; if (gnt_bus !== bus_m) begin failures++; $display("FAIL rnd_bus c=%0d got=%b exp=%b", c, gnt_bus, bus_m); end
      checks++; if (age_dbg !== pack_age()) begin failures++; $display("FAIL rnd_age c=%0d got=%h exp=%h", c, age_dbg, pack_age()); end
      checks++; if (promote_cnt !== 16'(prom_m)) begin failures++; $display("FAIL rnd_prom c=%0d got=%0d exp=%0d", c, promote_cnt, prom_m); end
    end
  endtask

  task automatic test_reset_mid();
    req = 6'b111111;
    flush = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    #1;
    model_clear(1'b1);
    checks++; if (gnt !== 6'b0) begin failures++; $display("FAIL mid_gnt got=%b exp=0", gnt); end
    checks++; if (age_dbg !== 24'b0) begin failures++; $display("FAIL mid_age got=%h exp=0", age_dbg); end
    checks++; if (promote_cnt !== 16'd0) begin failures++; $display("FAIL mid_prom got=%0d exp=0", promote_cnt); end
    reset = 1'b0;
    tick(6'b111111, 1'b0);
    checks++; if (gnt !== 6'b000111) begin failures++; $display("FAIL mid_after got=%b exp=000111", gnt); end
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    req = '0;
    test_reset();
    test_single();
    test_starve();
    test_flush();
    test_drop();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
